// File: rtl/btn_debounce_bank.sv
// Push-button front end: per-channel synchroniser, bounce filter, press/release
// pulses and long-press flag for N active-low buttons.
module btn_debounce_bank #(
   parameter int N_BTN           = 4,
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 1_000_000,
   parameter int HOLD_CYCLES     = 50_000_000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_BTN-1:0] btn_raw_n,
   output logic [N_BTN-1:0] btn_out_n,
   output logic [N_BTN-1:0] press_p,
   output logic [N_BTN-1:0] release_p,
   output logic [N_BTN-1:0] hold
);

   localparam int              DW     = $clog2(DEBOUNCE_CYCLES);
   localparam int              HW     = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;
   localparam logic [DW-1:0]   D_LAST = DW'(DEBOUNCE_CYCLES - 1);
   localparam logic [HW-1:0]   H_MAX  = HW'(HOLD_CYCLES);

   for (genvar i = 0; i < N_BTN; i++) begin : g_ch
      logic [SYNC_STAGES-1:0] sync_q, sync_d;
      logic [DW-1:0]          dcnt_q, dcnt_d;
      logic                   out_q, out_d;
      logic                   press_q, press_d;
      logic                   rel_q, rel_d;
      logic                   s;

      assign s = sync_q[SYNC_STAGES-1];

      // NOTE: every comb output gets a default before any branch, so no latch can be inferred.
      always_comb begin
         sync_d  = {sync_q[SYNC_STAGES-2:0], btn_raw_n[i]};
         dcnt_d  = '0;
         out_d   = out_q;
         press_d = 1'b0;
         rel_d   = 1'b0;
         if (s != out_q) begin
            if (dcnt_q == D_LAST) begin
               out_d   = s;
               press_d = ~s;
               rel_d   = s;
            end else begin
               dcnt_d = dcnt_q + 1'b1;
            end
         end
      end

      // NOTE: state flops use non-blocking assignments; reset is asynchronous and discards everything.
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            sync_q  <= '1;
            dcnt_q  <= '0;
            out_q   <= 1'b1;
            press_q <= 1'b0;
            rel_q   <= 1'b0;
         end else begin
            sync_q  <= sync_d;
            dcnt_q  <= dcnt_d;
            out_q   <= out_d;
            press_q <= press_d;
            rel_q   <= rel_d;
         end
      end

      assign btn_out_n[i] = out_q;
      assign press_p[i]   = press_q;
      assign release_p[i] = rel_q;

      if (HOLD_CYCLES > 0) begin : g_hold
         logic [HW-1:0] hcnt_q, hcnt_d;
         logic          hold_q, hold_d;

         // Clearing on the next level lets hold drop in the same cycle as release_p.
         always_comb begin
            hcnt_d = hcnt_q;
            hold_d = hold_q;
            if (out_d) begin
               hcnt_d = '0;
               hold_d = 1'b0;
            end else if (!out_q && hcnt_q != H_MAX) begin
               hcnt_d = hcnt_q + 1'b1;
               hold_d = (hcnt_q == H_MAX - 1'b1);
            end
         end

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               hcnt_q <= '0;
               hold_q <= 1'b0;
            end else begin
               hcnt_q <= hcnt_d;
               hold_q <= hold_d;
            end
         end

         assign hold[i] = hold_q;
      end else begin : g_no_hold
         assign hold[i] = 1'b0;
      end
   end

endmodule

// File: tb/tb_btn_debounce_bank.sv
// Bench for btn_debounce_bank: expected pulse/hold events are queued with their
// cycle stamp when stimulus is driven and matched against events seen on the outputs.
module tb_btn_debounce_bank;

   typedef struct {
      int         cyc;
      int         kind;   // 0 press, 1 release, 2 hold rise, 3 hold fall
      logic [3:0] vec;
   } ev_t;

   logic       clk;
   logic       rst;
   logic [3:0] btn_raw_n;
   logic [3:0] btn_out_n;
   logic [3:0] press_p;
   logic [3:0] release_p;
   logic [3:0] hold;

   int   cyc;
   int   n_cmp;
   int   n_err;
   logic [3:0] hold_prev;
   ev_t  exp_q[$];
   ev_t  obs_q[$];

   btn_debounce_bank #(
      .N_BTN(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(8), .HOLD_CYCLES(32)
   ) dut (
      .clk(clk), .rst(rst), .btn_raw_n(btn_raw_n), .btn_out_n(btn_out_n),
      .press_p(press_p), .release_p(release_p), .hold(hold)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic ev_t mk_ev(input int c, input int k, input logic [3:0] v);
      ev_t e;
      e.cyc  = c;
      e.kind = k;
      e.vec  = v;
      return e;
   endfunction

   // Records every output event with its cycle stamp; events caused by reset are ignored.
   initial hold_prev = 4'h0;
   always @(posedge clk) begin
      #1;
      if (!rst) begin
         if (press_p != 4'h0)                obs_q.push_back(mk_ev(cyc, 0, press_p));
         if (release_p != 4'h0)              obs_q.push_back(mk_ev(cyc, 1, release_p));
         if ((hold & ~hold_prev) != 4'h0)    obs_q.push_back(mk_ev(cyc, 2, hold & ~hold_prev));
         if ((~hold & hold_prev) != 4'h0)    obs_q.push_back(mk_ev(cyc, 3, ~hold & hold_prev));
      end
      hold_prev = hold;
   end

   task automatic run_to(input int n);
      repeat (n - cyc) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_reset();
      ev_t e, o;
      int  r;
      rst = 1'b1;
      btn_raw_n = 4'hF;
      repeat (3) @(negedge clk);
      n_cmp++;
      if ({btn_out_n, press_p, release_p, hold} !== 16'hF000) begin
         n_err++;
         $display("FAIL reset_active: got %h expected F000", {btn_out_n, press_p, release_p, hold});
      end
      rst = 1'b0;
      r = cyc;
      for (int k = 1; k <= 20; k++) begin
         run_to(r + k);
         n_cmp++;
         if ({btn_out_n, press_p, release_p, hold} !== 16'hF000) begin
            n_err++;
            $display("FAIL reset_idle cycle %0d: got %h expected F000", k, {btn_out_n, press_p, release_p, hold});
         end
      end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         n_cmp++;
         if (obs_q.size() == 0) begin
            n_err++;
            $display("FAIL reset event: got none expected cyc=%0d kind=%0d vec=%b", e.cyc, e.kind, e.vec);
         end else begin
            o = obs_q.pop_front();
            if (o.cyc !== e.cyc || o.kind !== e.kind || o.vec !== e.vec) begin
               n_err++;
               $display("FAIL reset event: got cyc=%0d kind=%0d vec=%b expected cyc=%0d kind=%0d vec=%b",
                        o.cyc, o.kind, o.vec, e.cyc, e.kind, e.vec);
            end
         end
      end
      n_cmp++;
      if (obs_q.size() != 0) begin
         n_err++;
         $display("FAIL reset extra events: got %0d expected 0", obs_q.size());
         obs_q.delete();
      end
   endtask

   task automatic test_clean_press();
      ev_t e, o;
      int  c, c2;
      @(negedge clk);
      btn_raw_n = 4'b1110;
      c = cyc;
      exp_q.push_back(mk_ev(c + 10, 0, 4'b0001));
      run_to(c + 9);
      n_cmp++;
      if (btn_out_n !== 4'b1111) begin
         n_err++;
         $display("FAIL press_early: btn_out_n got %b expected 1111", btn_out_n);
      end
      run_to(c + 10);
      n_cmp++;
      if (btn_out_n !== 4'b1110 || press_p !== 4'b0001) begin
         n_err++;
         $display("FAIL press_edge: btn_out_n/press_p got %b/%b expected 1110/0001", btn_out_n, press_p);
      end
      run_to(c + 11);
      n_cmp++;
      if (press_p !== 4'b0000) begin
         n_err++;
         $display("FAIL press_width: press_p got %b expected 0000", press_p);
      end
      @(negedge clk);
      btn_raw_n = 4'hF;
      c2 = cyc;
      exp_q.push_back(mk_ev(c2 + 10, 1, 4'b0001));
      run_to(c2 + 12);
      n_cmp++;
      if (btn_out_n !== 4'hF) begin
         n_err++;
         $display("FAIL press_released: btn_out_n got %b expected 1111", btn_out_n);
      end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         n_cmp++;
         if (obs_q.size() == 0) begin
            n_err++;
            $display("FAIL clean_press event: got none expected cyc=%0d kind=%0d vec=%b", e.cyc, e.kind, e.vec);
         end else begin
            o = obs_q.pop_front();
            if (o.cyc !== e.cyc || o.kind !== e.kind || o.vec !== e.vec) begin
               n_err++;
               $display("FAIL clean_press event: got cyc=%0d kind=%0d vec=%b expected cyc=%0d kind=%0d vec=%b",
                        o.cyc, o.kind, o.vec, e.cyc, e.kind, e.vec);
            end
         end
      end
      n_cmp++;
      if (obs_q.size() != 0) begin
         n_err++;
         $display("FAIL clean_press extra events: got %0d expected 0", obs_q.size());
         obs_q.delete();
      end
   endtask

   task automatic test_bounce();
      ev_t e, o;
      int  c, c2;
      @(negedge clk);
      btn_raw_n[1] = 1'b0;
      repeat (5) @(negedge clk);
      btn_raw_n[1] = 1'b1;
      repeat (2) @(negedge clk);
      btn_raw_n[1] = 1'b0;
      repeat (7) @(negedge clk);
      btn_raw_n[1] = 1'b1;
      c = cyc;
      run_to(c + 12);
      n_cmp++;
      if (btn_out_n !== 4'hF) begin
         n_err++;
         $display("FAIL bounce_filtered: btn_out_n got %b expected 1111", btn_out_n);
      end
      @(negedge clk);
      btn_raw_n[1] = 1'b0;
      c = cyc;
      exp_q.push_back(mk_ev(c + 10, 0, 4'b0010));
      run_to(c + 10);
      n_cmp++;
      if (btn_out_n !== 4'b1101) begin
         n_err++;
         $display("FAIL bounce_accept: btn_out_n got %b expected 1101", btn_out_n);
      end
      @(negedge clk);
      btn_raw_n[1] = 1'b1;
      c2 = cyc;
      exp_q.push_back(mk_ev(c2 + 10, 1, 4'b0010));
      run_to(c2 + 12);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         n_cmp++;
         if (obs_q.size() == 0) begin
            n_err++;
            $display("FAIL bounce event: got none expected cyc=%0d kind=%0d vec=%b", e.cyc, e.kind, e.vec);
         end else begin
            o = obs_q.pop_front();
            if (o.cyc !== e.cyc || o.kind !== e.kind || o.vec !== e.vec) begin
               n_err++;
               $display("FAIL bounce event: got cyc=%0d kind=%0d vec=%b expected cyc=%0d kind=%0d vec=%b",
                        o.cyc, o.kind, o.vec, e.cyc, e.kind, e.vec);
            end
         end
      end
      n_cmp++;
      if (obs_q.size() != 0) begin
         n_err++;
         $display("FAIL bounce extra events: got %0d expected 0", obs_q.size());
         obs_q.delete();
      end
   endtask

   task automatic test_long_press();
      ev_t e, o;
      int  c, c2;
      @(negedge clk);
      btn_raw_n[2] = 1'b0;
      c = cyc;
      exp_q.push_back(mk_ev(c + 10, 0, 4'b0100));
      exp_q.push_back(mk_ev(c + 42, 2, 4'b0100));
      run_to(c + 41);
      n_cmp++;
      if (hold !== 4'b0000) begin
         n_err++;
         $display("FAIL hold_early: hold got %b expected 0000", hold);
      end
      run_to(c + 42);
      n_cmp++;
      if (hold !== 4'b0100) begin
         n_err++;
         $display("FAIL hold_rise: hold got %b expected 0100", hold);
      end
      run_to(c + 60);
      @(negedge clk);
      btn_raw_n[2] = 1'b1;
      c2 = cyc;
      exp_q.push_back(mk_ev(c2 + 10, 1, 4'b0100));
      exp_q.push_back(mk_ev(c2 + 10, 3, 4'b0100));
      run_to(c2 + 10);
      n_cmp++;
      if ({btn_out_n, release_p, hold} !== 12'hF40) begin
         n_err++;
         $display("FAIL hold_release: btn_out_n/release_p/hold got %b/%b/%b expected 1111/0100/0000",
                  btn_out_n, release_p, hold);
      end
      run_to(c2 + 12);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         n_cmp++;
         if (obs_q.size() == 0) begin
            n_err++;
            $display("FAIL long_press event: got none expected cyc=%0d kind=%0d vec=%b", e.cyc, e.kind, e.vec);
         end else begin
            o = obs_q.pop_front();
            if (o.cyc !== e.cyc || o.kind !== e.kind || o.vec !== e.vec) begin
               n_err++;
               $display("FAIL long_press event: got cyc=%0d kind=%0d vec=%b expected cyc=%0d kind=%0d vec=%b",
                        o.cyc, o.kind, o.vec, e.cyc, e.kind, e.vec);
            end
         end
      end
      n_cmp++;
      if (obs_q.size() != 0) begin
         n_err++;
         $display("FAIL long_press extra events: got %0d expected 0", obs_q.size());
         obs_q.delete();
      end
   endtask

   task automatic test_simultaneous();
      ev_t e, o;
      int  c, c2, c3;
      @(negedge clk);
      btn_raw_n = 4'b0110;
      c = cyc;
      exp_q.push_back(mk_ev(c + 10, 0, 4'b1001));
      run_to(c + 10);
      n_cmp++;
      if (press_p !== 4'b1001) begin
         n_err++;
         $display("FAIL simul_press: press_p got %b expected 1001", press_p);
      end
      @(negedge clk);
      btn_raw_n[0] = 1'b1;
      c2 = cyc;
      repeat (3) @(negedge clk);
      btn_raw_n[3] = 1'b1;
      c3 = cyc;
      exp_q.push_back(mk_ev(c2 + 10, 1, 4'b0001));
      exp_q.push_back(mk_ev(c3 + 10, 1, 4'b1000));
      run_to(c3 + 12);
      n_cmp++;
      if (btn_out_n !== 4'hF) begin
         n_err++;
         $display("FAIL simul_idle: btn_out_n got %b expected 1111", btn_out_n);
      end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         n_cmp++;
         if (obs_q.size() == 0) begin
            n_err++;
            $display("FAIL simultaneous event: got none expected cyc=%0d kind=%0d vec=%b", e.cyc, e.kind, e.vec);
         end else begin
            o = obs_q.pop_front();
            if (o.cyc !== e.cyc || o.kind !== e.kind || o.vec !== e.vec) begin
               n_err++;
               $display("FAIL simultaneous event: got cyc=%0d kind=%0d vec=%b expected cyc=%0d kind=%0d vec=%b",
                        o.cyc, o.kind, o.vec, e.cyc, e.kind, e.vec);
            end
         end
      end
      n_cmp++;
      if (obs_q.size() != 0) begin
         n_err++;
         $display("FAIL simultaneous extra events: got %0d expected 0", obs_q.size());
         obs_q.delete();
      end
   endtask

   task automatic test_reset_mid();
      ev_t e, o;
      int  c, r, r2, c3;
      @(negedge clk);
      btn_raw_n = 4'b1001;
      c = cyc;
      run_to(c + 4);
      @(negedge clk);
      rst = 1'b1;
      #1;
      n_cmp++;
      if ({btn_out_n, press_p, release_p, hold} !== 16'hF000) begin
         n_err++;
         $display("FAIL rst_mid_debounce: got %h expected F000", {btn_out_n, press_p, release_p, hold});
      end
      repeat (2) @(negedge clk);
      rst = 1'b0;
      r = cyc;
      exp_q.push_back(mk_ev(r + 10, 0, 4'b0110));
      exp_q.push_back(mk_ev(r + 42, 2, 4'b0110));
      run_to(r + 9);
      n_cmp++;
      if (btn_out_n !== 4'hF) begin
         n_err++;
         $display("FAIL rst_mid_early: btn_out_n got %b expected 1111", btn_out_n);
      end
      run_to(r + 10);
      n_cmp++;
      if (btn_out_n !== 4'b1001 || press_p !== 4'b0110) begin
         n_err++;
         $display("FAIL rst_mid_press: btn_out_n/press_p got %b/%b expected 1001/0110", btn_out_n, press_p);
      end
      run_to(r + 42);
      n_cmp++;
      if (hold !== 4'b0110) begin
         n_err++;
         $display("FAIL rst_mid_hold: hold got %b expected 0110", hold);
      end
      @(negedge clk);
      rst = 1'b1;
      #1;
      n_cmp++;
      if ({btn_out_n, press_p, release_p, hold} !== 16'hF000) begin
         n_err++;
         $display("FAIL rst_mid_hold_reset: got %h expected F000", {btn_out_n, press_p, release_p, hold});
      end
      repeat (2) @(negedge clk);
      rst = 1'b0;
      r2 = cyc;
      exp_q.push_back(mk_ev(r2 + 10, 0, 4'b0110));
      run_to(r2 + 10);
      n_cmp++;
      if (press_p !== 4'b0110) begin
         n_err++;
         $display("FAIL rst_mid_repress: press_p got %b expected 0110", press_p);
      end
      @(negedge clk);
      btn_raw_n = 4'hF;
      c3 = cyc;
      exp_q.push_back(mk_ev(c3 + 10, 1, 4'b0110));
      run_to(c3 + 12);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         n_cmp++;
         if (obs_q.size() == 0) begin
            n_err++;
            $display("FAIL reset_mid event: got none expected cyc=%0d kind=%0d vec=%b", e.cyc, e.kind, e.vec);
         end else begin
            o = obs_q.pop_front();
            if (o.cyc !== e.cyc || o.kind !== e.kind || o.vec !== e.vec) begin
               n_err++;
               $display("FAIL reset_mid event: got cyc=%0d kind=%0d vec=%b expected cyc=%0d kind=%0d vec=%b",
                        o.cyc, o.kind, o.vec, e.cyc, e.kind, e.vec);
            end
         end
      end
      n_cmp++;
      if (obs_q.size() != 0) begin
         n_err++;
         $display("FAIL reset_mid extra events: got %0d expected 0", obs_q.size());
         obs_q.delete();
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      n_cmp = 0;
      n_err = 0;
      rst = 1'b1;
      btn_raw_n = 4'hF;
      test_reset();
      test_clean_press();
      test_bounce();
      test_long_press();
      test_simultaneous();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
